// File: rtl/sram_controller_v2.sv
// Controller for a 16-bit asynchronous SRAM. It splits each DATA_WIDTH request into
// 16-bit beats, low word first, with WAIT_STATES extra cycles per beat and write recovery.
module sram_controller_v2 #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h80000000),
   parameter int                    WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_rnw,
   input  logic [ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_data,
   input  logic [DATA_WIDTH/8-1:0] i_req_byte_en,
   output logic                    o_rsp_valid,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic                    o_rsp_err,
   output logic [19:0]             o_sram_addr,
   inout  wire  [15:0]             io_sram_dq,
   output logic                    o_sram_ce_n,
   output logic                    o_sram_we_n,
   output logic                    o_sram_oe_n,
   output logic                    o_sram_lb_n,
   output logic                    o_sram_ub_n
);

   localparam int BEATS = DATA_WIDTH / 16;
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
   localparam logic [2:0]            LAST_CYC  = 3'(WAIT_STATES);
   localparam logic [19:0]           AMASK     = ~20'((1 << $clog2(BEATS)) - 1);
   localparam logic [ADDR_WIDTH-1:0] WIN       = ADDR_WIDTH'(64'h200000);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state, w_nxt_state;
   logic [BW-1:0]         r_beat, w_nxt_beat;
   logic [2:0]            r_cyc, w_nxt_cyc;
   logic                  r_rnw, w_rnw_n;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
   logic [BE_W-1:0]       r_be, w_be_n;
   logic [DATA_WIDTH-1:0] r_rd_asm, r_rd_last, w_rd_asm;
   logic [19:0]           r_addr, w_start;
   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_accept, w_in_range, w_beat_end;
   logic [1:0]            w_ben2;
   logic [15:0]           w_slot, r_dq_out;
   logic                  r_ce_n, r_we_n, r_oe_n, r_lb_n, r_ub_n, r_dq_oe;
   logic                  w_ce_n, w_we_n, w_oe_n, w_lb_n, w_ub_n, w_dq_oe;
   logic                  r_rsp_valid, r_rsp_err, r_rsp_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt_state;
   end

   always_comb begin
      w_off       = i_req_addr - BASE_ADDR;
      w_in_range  = (i_req_addr >= BASE_ADDR) && (w_off < WIN);
      w_start     = w_off[20:1] & AMASK;
      w_accept    = (r_state == S_IDLE) && i_req_valid;
      w_beat_end  = (r_cyc == LAST_CYC);
      w_nxt_state = r_state;
      w_nxt_beat  = r_beat;
      w_nxt_cyc   = r_cyc;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_nxt_state = w_in_range ? S_ACCESS : S_RESP;
               w_nxt_beat  = '0;
               w_nxt_cyc   = '0;
            end
         end
         S_ACCESS: begin
            if (!w_beat_end) begin
               w_nxt_cyc = r_cyc + 3'd1;
            end else if (r_beat == LAST_BEAT) begin
               w_nxt_state = S_RESP;
            end else begin
               w_nxt_beat = r_beat + BW'(1);
               w_nxt_cyc  = '0;
            end
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Strobes are computed for the coming cycle and registered, so the pins are glitch-free.
   always_comb begin
      w_rnw_n   = w_accept ? i_req_rnw     : r_rnw;
      w_be_n    = w_accept ? i_req_byte_en : r_be;
      w_wdata_n = w_accept ? i_req_data    : r_wdata;
      w_ben2    = '0;
      w_slot    = '0;
      w_rd_asm  = r_rd_asm;
      for (int k = 0; k < BEATS; k++) begin
         if (w_nxt_beat == BW'(k)) begin
            w_ben2 = w_be_n[2*k +: 2];
            w_slot = w_wdata_n[16*k +: 16];
         end
         if (r_beat == BW'(k)) w_rd_asm[16*k +: 16] = io_sram_dq;
      end
      w_ce_n  = 1'b1;
      w_we_n  = 1'b1;
      w_oe_n  = 1'b1;
      w_lb_n  = 1'b1;
      w_ub_n  = 1'b1;
      w_dq_oe = 1'b0;
      if (w_nxt_state == S_ACCESS) begin
         w_ce_n = 1'b0;
         if (w_rnw_n) begin
            w_oe_n = 1'b0;
            w_lb_n = 1'b0;
            w_ub_n = 1'b0;
         end else begin
            w_dq_oe = 1'b1;
            w_lb_n  = ~w_ben2[0];
            w_ub_n  = ~w_ben2[1];
            // Last cycle of a waited beat releases we_n with address and data held.
            w_we_n  = (w_ben2 == 2'b00) || ((WAIT_STATES != 0) && (w_nxt_cyc == LAST_CYC));
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat      <= '0;
         r_cyc       <= '0;
         r_rnw       <= 1'b1;
         r_wdata     <= '0;
         r_be        <= '0;
         r_addr      <= '0;
         r_rd_asm    <= '0;
         r_rd_last   <= '0;
         r_ce_n      <= 1'b1;
         r_we_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_lb_n      <= 1'b1;
         r_ub_n      <= 1'b1;
         r_dq_oe     <= 1'b0;
         r_dq_out    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_zero  <= 1'b0;
      end else begin
         r_beat      <= w_nxt_beat;
         r_cyc       <= w_nxt_cyc;
         r_ce_n      <= w_ce_n;
         r_we_n      <= w_we_n;
         r_oe_n      <= w_oe_n;
         r_lb_n      <= w_lb_n;
         r_ub_n      <= w_ub_n;
         r_dq_oe     <= w_dq_oe;
         r_dq_out    <= w_slot;
         r_rsp_valid <= (w_nxt_state == S_RESP);
         r_rsp_err   <= w_accept && !w_in_range;
         r_rsp_zero  <= (r_state == S_ACCESS) ? !r_rnw : 1'b1;
         if (w_accept) begin
            r_rnw   <= i_req_rnw;
            r_wdata <= i_req_data;
            r_be    <= i_req_byte_en;
         end
         if (w_accept && w_in_range)
            r_addr <= w_start;
         else if ((r_state == S_ACCESS) && w_beat_end && (r_beat != LAST_BEAT))
            r_addr <= r_addr + 20'd1;
         if ((r_state == S_ACCESS) && r_rnw && w_beat_end) begin
            r_rd_asm <= w_rd_asm;
            if (r_beat == LAST_BEAT) r_rd_last <= w_rd_asm;
         end
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_data  = (r_rsp_valid && r_rsp_zero) ? '0 : r_rd_last;
   assign o_sram_addr = r_addr;
   assign o_sram_ce_n = r_ce_n;
   assign o_sram_we_n = r_we_n;
   assign o_sram_oe_n = r_oe_n;
   assign o_sram_lb_n = r_lb_n;
   assign o_sram_ub_n = r_ub_n;
   assign io_sram_dq  = r_dq_oe ? r_dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller_v2.sv
// Bench for sram_controller_v2: a 32-bit zero-wait instance and a 64-bit two-wait instance,
// each with a behavioural SRAM and a response scoreboard.
module tb_sram_controller_v2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          due;
   } exp_t;
   exp_t sb0[$];
   exp_t sb1[$];

   // 32-bit, zero wait states
   logic        rst0, v0, rdy0, rnw0, rv0, re0;
   logic [31:0] a0, d0, rd0;
   logic [3:0]  be0;
   logic [19:0] sa0;
   wire  [15:0] dq0;
   logic        ce0, we0, oe0, lb0, ub0;
   sram_controller_v2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h80000000), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst0), .i_req_valid(v0), .o_req_ready(rdy0), .i_req_rnw(rnw0),
      .i_req_addr(a0), .i_req_data(d0), .i_req_byte_en(be0), .o_rsp_valid(rv0),
      .o_rsp_data(rd0), .o_rsp_err(re0), .o_sram_addr(sa0), .io_sram_dq(dq0),
      .o_sram_ce_n(ce0), .o_sram_we_n(we0), .o_sram_oe_n(oe0), .o_sram_lb_n(lb0), .o_sram_ub_n(ub0));

   // 64-bit, two wait states
   logic        rst1, v1, rdy1, rnw1, rv1, re1;
   logic [31:0] a1;
   logic [63:0] d1, rd1;
   logic [7:0]  be1;
   logic [19:0] sa1;
   wire  [15:0] dq1;
   logic        ce1, we1, oe1, lb1, ub1;
   sram_controller_v2 #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BASE_ADDR(32'h80000000), .WAIT_STATES(2)) u_dut1 (
      .clk(clk), .rst(rst1), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_rnw(rnw1),
      .i_req_addr(a1), .i_req_data(d1), .i_req_byte_en(be1), .o_rsp_valid(rv1),
      .o_rsp_data(rd1), .o_rsp_err(re1), .o_sram_addr(sa1), .io_sram_dq(dq1),
      .o_sram_ce_n(ce1), .o_sram_we_n(we1), .o_sram_oe_n(oe1), .o_sram_lb_n(lb1), .o_sram_ub_n(ub1));

   // Behavioural SRAMs
   logic [15:0] mem0 [0:1048575];
   logic [15:0] mem1 [0:1048575];
   assign dq0 = (!ce0 && !oe0 && we0) ? mem0[sa0] : 16'hzzzz;
   assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 16'hzzzz;
   always @(posedge clk) begin
      if (!ce0 && !we0) begin
         if (!lb0) mem0[sa0][7:0]  <= dq0[7:0];
         if (!ub0) mem0[sa0][15:8] <= dq0[15:8];
      end
      if (!ce1 && !we1) begin
         if (!lb1) mem1[sa1][7:0]  <= dq1[7:0];
         if (!ub1) mem1[sa1][15:8] <= dq1[15:8];
      end
   end

   int wep0 = 0;
   always @(negedge clk) if (!we0) wep0++;

   // Response scoreboards
   always @(negedge clk) begin : mon0
      exp_t e;
      if (rv0) begin
         n_chk++;
         if (sb0.size() == 0) begin
            $display("FAIL rsp0_unexpected got data=%h err=%b at cyc=%0d, required no response", rd0, re0, cyc);
         end else begin
            e = sb0.pop_front();
            if (rd0 !== e.data[31:0] || re0 !== e.err || cyc != e.due)
               $display("FAIL rsp0 got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                        rd0, re0, cyc, e.data[31:0], e.err, e.due);
            else n_pass++;
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rv1) begin
         n_chk++;
         if (sb1.size() == 0) begin
            $display("FAIL rsp1_unexpected got data=%h err=%b at cyc=%0d, required no response", rd1, re1, cyc);
         end else begin
            e = sb1.pop_front();
            if (rd1 !== e.data || re1 !== e.err || cyc != e.due)
               $display("FAIL rsp1 got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                        rd1, re1, cyc, e.data, e.err, e.due);
            else n_pass++;
         end
      end
   end

   // Returns at the falling edge of cycle 1 (the cycle after the accept edge).
   task automatic issue0(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic [31:0] xdata, input logic xerr,
                         input int lat, input bit push, output int acc);
      int t = 0;
      @(negedge clk);
      v0 = 1'b1; rnw0 = rnw; a0 = addr; d0 = data; be0 = be;
      while (!rdy0 && t < 100) begin @(negedge clk); t++; end
      n_chk++;
      if (!rdy0) $display("FAIL issue0_ready got %b required 1", rdy0);
      else n_pass++;
      if (push) sb0.push_back('{{32'h0, xdata}, xerr, cyc + lat});
      @(negedge clk);
      acc = cyc;
      v0 = 1'b0;
   endtask

   task automatic issue1(input logic rnw, input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] be, input logic [63:0] xdata, input logic xerr,
                         input int lat, output int acc);
      int t = 0;
      @(negedge clk);
      v1 = 1'b1; rnw1 = rnw; a1 = addr; d1 = data; be1 = be;
      while (!rdy1 && t < 100) begin @(negedge clk); t++; end
      n_chk++;
      if (!rdy1) $display("FAIL issue1_ready got %b required 1", rdy1);
      else n_pass++;
      sb1.push_back('{xdata, xerr, cyc + lat});
      @(negedge clk);
      acc = cyc;
      v1 = 1'b0;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst1 = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({rdy0, rv0, re0, ce0, we0, oe0, lb0, ub0} !== 8'b1001_1111 || rd0 !== 32'h0 || sa0 !== 20'h0)
         $display("FAIL reset0 got ctl=%b data=%h addr=%h required ctl=10011111 data=0 addr=0",
                  {rdy0, rv0, re0, ce0, we0, oe0, lb0, ub0}, rd0, sa0);
      else n_pass++;
      n_chk++;
      if ({rdy1, rv1, re1, ce1, we1, oe1, lb1, ub1} !== 8'b1001_1111 || rd1 !== 64'h0 || sa1 !== 20'h0)
         $display("FAIL reset1 got ctl=%b data=%h addr=%h required ctl=10011111 data=0 addr=0",
                  {rdy1, rv1, re1, ce1, we1, oe1, lb1, ub1}, rd1, sa1);
      else n_pass++;
      rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({rdy0, rv0, ce0, rdy1, rv1, ce1} !== 6'b101_101)
         $display("FAIL post_reset got %b required 101101", {rdy0, rv0, ce0, rdy1, rv1, ce1});
      else n_pass++;
   endtask

   task automatic test_write_read();
      int acc;
      issue0(1'b0, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3, 1'b1, acc);
      n_chk++;
      if ({sa0, ce0, we0, oe0} !== {20'd8, 3'b001})
         $display("FAIL wr_beat0 got addr=%h ce/we/oe=%b required addr=8 001", sa0, {ce0, we0, oe0});
      else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++;
      if (mem0[8] !== 16'hBEEF || mem0[9] !== 16'hDEAD)
         $display("FAIL wr_mem got w8=%h w9=%h required BEEF DEAD", mem0[8], mem0[9]);
      else n_pass++;
      issue0(1'b1, 32'h80000010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, acc);
      n_chk++;
      if ({sa0, ce0, we0, oe0, lb0, ub0} !== {20'd8, 5'b01000})
         $display("FAIL rd_beat0 got addr=%h strobes=%b required addr=8 01000", sa0, {ce0, we0, oe0, lb0, ub0});
      else n_pass++;
   endtask

   task automatic test_byte_en();
      int acc;
      issue0(1'b0, 32'h80000020, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 3, 1'b1, acc);
      issue0(1'b0, 32'h80000020, 32'h11223344, 4'b0110, 32'h0, 1'b0, 3, 1'b1, acc);
      n_chk++;
      if ({lb0, ub0, we0} !== 3'b100)
         $display("FAIL be_beat0 got lb/ub/we=%b required 100", {lb0, ub0, we0});
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({lb0, ub0, we0} !== 3'b010)
         $display("FAIL be_beat1 got lb/ub/we=%b required 010", {lb0, ub0, we0});
      else n_pass++;
      issue0(1'b1, 32'h80000020, 32'h0, 4'h0, 32'hFF2233FF, 1'b0, 3, 1'b1, acc);
   endtask

   task automatic test_out_of_range();
      int acc, w;
      issue0(1'b1, 32'h7FFFFFFC, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1, acc);
      w = wep0;
      issue0(1'b0, 32'h80200000, 32'h55AA55AA, 4'hF, 32'h0, 1'b1, 1, 1'b1, acc);
      repeat (3) @(negedge clk);
      n_chk++;
      if (wep0 != w) $display("FAIL oor_write_we got %0d we_n-low cycles required 0", wep0 - w);
      else n_pass++;
   endtask

   task automatic test_last_word();
      int acc;
      issue0(1'b0, 32'h801FFFFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3, 1'b1, acc);
      n_chk++;
      if (sa0 !== 20'hFFFFE) $display("FAIL last_wr_a0 got %h required FFFFE", sa0);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (sa0 !== 20'hFFFFF) $display("FAIL last_wr_a1 got %h required FFFFF", sa0);
      else n_pass++;
      issue0(1'b1, 32'h801FFFFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1, acc);
      @(negedge clk);
      n_chk++;
      if (sa0 !== 20'hFFFFF || mem0[20'hFFFFF] !== 16'hCAFE)
         $display("FAIL last_rd got addr=%h mem=%h required FFFFF CAFE", sa0, mem0[20'hFFFFF]);
      else n_pass++;
   endtask

   task automatic test_ws2();
      int acc;
      logic [19:0] xa;
      logic xwe;
      issue1(1'b0, 32'h80000008, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, 13, acc);
      for (int n = 1; n <= 14; n++) begin
         n_chk++;
         xa  = 20'd4 + 20'((n - 1) / 3);
         xwe = ((n - 1) % 3 == 2);
         if (n <= 12) begin
            if ({sa1, ce1, we1, oe1, rdy1} !== {xa, 1'b0, xwe, 1'b1, 1'b0})
               $display("FAIL ws2_wr c%0d got addr=%h ce/we/oe/rdy=%b required addr=%h %b",
                        n, sa1, {ce1, we1, oe1, rdy1}, xa, {1'b0, xwe, 1'b1, 1'b0});
            else n_pass++;
         end else if ({ce1, rdy1} !== {1'b1, n == 14}) begin
            $display("FAIL ws2_wr c%0d got ce/rdy=%b required %b", n, {ce1, rdy1}, {1'b1, n == 14});
         end else n_pass++;
         if (n < 14) @(negedge clk);
      end
      n_chk++;
      if ({mem1[7], mem1[6], mem1[5], mem1[4]} !== 64'h0123456789ABCDEF)
         $display("FAIL ws2_mem got %h required 0123456789abcdef", {mem1[7], mem1[6], mem1[5], mem1[4]});
      else n_pass++;
      issue1(1'b1, 32'h8000000C, 64'h0, 8'h0, 64'h0123456789ABCDEF, 1'b0, 13, acc);
      for (int n = 1; n <= 14; n++) begin
         n_chk++;
         xa = 20'd4 + 20'((n - 1) / 3);
         if (n <= 12) begin
            if ({sa1, ce1, we1, oe1, rdy1} !== {xa, 4'b0100})
               $display("FAIL ws2_rd c%0d got addr=%h ce/we/oe/rdy=%b required addr=%h 0100",
                        n, sa1, {ce1, we1, oe1, rdy1}, xa);
            else n_pass++;
         end else if ({ce1, rdy1} !== {1'b1, n == 14}) begin
            $display("FAIL ws2_rd c%0d got ce/rdy=%b required %b", n, {ce1, rdy1}, {1'b1, n == 14});
         end else n_pass++;
         if (n < 14) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_beat();
      int acc;
      issue0(1'b0, 32'h80000040, 32'h12345678, 4'hF, 32'h0, 1'b0, 3, 1'b0, acc);
      @(negedge clk);
      rst0 = 1'b1;
      #1;
      n_chk++;
      if ({ce0, we0, oe0, lb0, ub0, rv0, rdy0} !== 7'b11111_01 || dq0 === 16'h1234)
         $display("FAIL rst_mid got strobes/rv/rdy=%b dq=%h required 1111101 and dq released",
                  {ce0, we0, oe0, lb0, ub0, rv0, rdy0}, dq0);
      else n_pass++;
      @(negedge clk);
      rst0 = 1'b0;
      repeat (4) @(negedge clk);
      issue0(1'b0, 32'h80000040, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0, 3, 1'b1, acc);
      issue0(1'b1, 32'h80000040, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0, 3, 1'b1, acc);
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      v0 = 1'b0; rnw0 = 1'b1; a0 = '0; d0 = '0; be0 = '0;
      v1 = 1'b0; rnw1 = 1'b1; a1 = '0; d1 = '0; be1 = '0;
      test_reset();
      test_write_read();
      test_byte_en();
      test_out_of_range();
      test_last_word();
      test_ws2();
      test_reset_mid_beat();
      for (int t = 0; t < 50 && (sb0.size() != 0 || sb1.size() != 0); t++) @(negedge clk);
      n_chk++;
      if (sb0.size() != 0 || sb1.size() != 0)
         $display("FAIL drain got %0d/%0d responses outstanding required 0/0", sb0.size(), sb1.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_controller_v2.md
# sram_controller_v2

Parametrised controller for the 16-bit asynchronous SRAM (IS61WV102416BLL class, 1M x 16). It turns single-word requests of any multiple-of-16 width into a sequence of 16-bit SRAM beats. Each beat has a configurable number of wait states, and writes carry per-byte enables. Out-of-range accesses return an error response. It sits between the system interconnect slave port and the SRAM pins, and supersedes the fixed 32-bit, zero-wait controller.

## Interface
- DATA_WIDTH, 32: request word width; multiple of 16, range 16..128; BEATS = DATA_WIDTH/16.
- ADDR_WIDTH, 32: byte address width.
- BASE_ADDR, 32'h80000000: first byte address of the SRAM window; window span 2 MiB.
- WAIT_STATES, 0: extra cycles per beat, range 0..7; beat length L = WAIT_STATES+1 cycles.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  controller can accept; request accepted on the edge where valid && ready.
- i_req_rnw  in  1  1 = read, 0 = write.
- i_req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored (aligned).
- i_req_data  in  DATA_WIDTH  write data.
- i_req_byte_en  in  DATA_WIDTH/8  write byte enables; ignored for reads.
- o_rsp_valid  out  1  one-cycle response pulse; no backpressure.
- o_rsp_data  out  DATA_WIDTH  read data, valid with o_rsp_valid; zero for writes and errors.
- o_rsp_err  out  1  request address outside window, valid with o_rsp_valid.
- o_sram_addr  out  20  SRAM word address.
- io_sram_dq  inout  16  SRAM data; driven only during write beats, else high-Z.
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low.

## Operation
- States: IDLE, ACCESS, RESP.
  - IDLE: o_req_ready=1. On accept, latch rnw, data, byte_en and start address; then go to ACCESS, or to RESP directly if out of range.
  - ACCESS: run beats 0..BEATS-1; after the last cycle of beat BEATS-1, go to RESP.
  - RESP: o_rsp_valid=1 for exactly one cycle, then go to IDLE.
- Address mapping: offset = i_req_addr - BASE_ADDR. In range iff i_req_addr >= BASE_ADDR and offset < 2^21. Start word address = offset[20:1] with the low log2(BEATS) bits forced to 0.
- Beat k uses address start + k, modulo 2^20. Alignment guarantees no wrap inside a request; the counter still wraps mod 2^20.
- Beat k carries bits [16k+15:16k]. Low word goes first, and read data assembles little-endian the same way.
- Read beat:
  - ce_n=0, oe_n=0, we_n=1, lb_n=ub_n=0, dq high-Z.
  - io_sram_dq is sampled into slot k on the last cycle of the beat.
- Write beat:
  - ce_n=0, oe_n=1, dq driven with slot k.
  - lb_n = ~byte_en[2k], ub_n = ~byte_en[2k+1].
  - we_n=0 for the whole beat if WAIT_STATES=0. Otherwise we_n=0 for the first L-1 cycles and 1 in the last cycle, with address and data held, for write recovery.
  - A beat whose two enables are both 0 still takes L cycles, with we_n=1.
- IDLE/RESP: ce_n=we_n=oe_n=lb_n=ub_n=1, address holds last value, dq high-Z.
- Error request: no SRAM cycle, o_rsp_err=1, o_rsp_data=0; writes are discarded.
- Output holds between responses: o_rsp_data holds the last read data; o_rsp_err=0 outside RESP.

## Timing
- Accept on edge 0. Beat k occupies cycles 1+k·L .. (k+1)·L. RESP is cycle BEATS·L+1. o_req_ready returns in cycle BEATS·L+2.
- Worked latency: DATA_WIDTH=32, WAIT_STATES=0 gives rsp_valid 3 cycles after accept.
- Error latency: rsp_valid in cycle 1.
- Throughput: one request per BEATS·L+2 cycles; o_req_ready=0 in ACCESS and RESP.
- Strobe and address outputs are registered (glitch-free). dq enable changes on the same edges as we_n.
- Reset, asserted at any time including mid-beat:
  - State goes to IDLE and o_req_ready=1.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_data=0, o_sram_addr=0.
  - All SRAM strobes go to 1 and dq to high-Z, asynchronously.
  - The in-flight request is dropped with no response.

## Test plan
- DATA_WIDTH=32, WS=0: write 0xDEADBEEF to 0x80000010, byte_en=4'hF, then read it back. Required: SRAM word 8 = 0xBEEF, word 9 = 0xDEAD; read rsp_data=0xDEADBEEF, err=0; rsp_valid 3 cycles after each accept.
- Byte enables: write 0x11223344 with byte_en=4'b0110 over a pre-filled 0xFFFFFFFF, then read. Required: rsp_data=0xFF2233FF; beat 0 lb_n=1, ub_n=0; beat 1 lb_n=0, ub_n=1.
- WS=2, DATA_WIDTH=64: read from 0x80000008. Required: addresses 4,5,6,7 each held 3 cycles; rsp_valid at cycle 13 after accept; o_req_ready low cycles 1-13.
- Out of range:
  - Read 0x7FFFFFFC: rsp_valid in cycle 1 with err=1, data=0.
  - Write 0x80200000: err=1, no we_n pulse.
- Last word: read/write 0x801FFFFC (DATA_WIDTH=32). Required: addresses 0xFFFFE and 0xFFFFF, err=0.
- Assert rst during beat 1 of a write. Required: strobes high and dq high-Z in the same cycle, no rsp_valid; a subsequent request completes normally.
